vgaout_gen: RTL

Parametrised successor to the fixed 720x400@70 status display generator. Produces raster timing (hs/vs/de) and a multi-row, multi-digit hex readout overlay on a solid background, with every timing value, channel count, digit count, glyph scale and colour depth set by parameters. Values are captured once per frame so a row never tears, and each row can be individually hidden or blinked. Sits between the memory-test core status registers and the MiSTer video output path.

---
 rtl/vgaout_pkg.sv | 19 +
 rtl/hexglyph.sv | 34 +++
 rtl/vgaout_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vgaout_pkg.sv
// Shared constants for the hex readout overlay: glyph grid geometry,
// colour width helper and the 7-segment table for hex digits 0-F.
package vgaout_pkg;

  localparam int GLYPH_COLS       = 5;
  localparam int GLYPH_ROWS       = 5;
  localparam int GLYPH_PITCH_LOG2 = 3;

  // Segment bits are {g,f,e,d,c,b,a}; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int rgb_w(input int cw);
    return 3 * cw;
  endfunction

endpackage

// File: rtl/hexglyph.sv
// Combinational 5x5 seven-segment renderer: one hex digit, one glyph cell in,
// lit/unlit out. Corner cells merge the two segments that meet there.
module hexglyph
  import vgaout_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] col,
  input  logic [2:0] row,
  output logic       lit
);

  logic [6:0] seg;
  logic       sa, sb, sc, sd, se, sf, sg;
  logic       left, right;

  assign seg   = SEG_TABLE[digit];
  assign {sg, sf, se, sd, sc, sb, sa} = seg;
  assign left  = (col == 3'd0);
  assign right = (col == 3'(GLYPH_COLS - 1));

  always_comb begin
    lit = 1'b0;
    if ((col < 3'(GLYPH_COLS)) && (row < 3'(GLYPH_ROWS))) begin
      case (row)
        3'd0:    lit = sa | (left & sf) | (right & sb);
        3'd1:    lit = (left & sf) | (right & sb);
        3'd2:    lit = left ? (sf | se) : (right ? (sb | sc) : sg);
        3'd3:    lit = (left & se) | (right & sc);
        default: lit = left ? (se | sd) : (right ? (sc | sd) : sd);
      endcase
    end
  end

endmodule

// File: rtl/vgaout_gen.sv
// Parametrised raster generator with a multi-row hex readout overlay whose
// inputs are latched once per frame so a row never tears.
module vgaout_gen
  import vgaout_pkg::*;
#(
  parameter int   H_ACTIVE   = 720,
  parameter int   H_FRONT    = 20,
  parameter int   H_SYNC     = 62,
  parameter int   H_BACK     = 56,
  parameter int   V_ACTIVE   = 400,
  parameter int   V_FRONT    = 12,
  parameter int   V_SYNC     = 6,
  parameter int   V_BACK     = 107,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b1,
  parameter int   NCH        = 3,
  parameter int   DIGITS     = 8,
  parameter int   SCALE_LOG2 = 3,
  parameter int   X0         = 112,
  parameter int   Y0         = 80,
  parameter int   CW         = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce_pix,
  input  logic [NCH*DIGITS*4-1:0]   values,
  input  logic [NCH-1:0]            ch_en,
  input  logic [NCH-1:0]            ch_blink,
  input  logic [NCH*rgb_w(CW)-1:0]  fg,
  input  logic [rgb_w(CW)-1:0]      bg,
  output logic                      hs,
  output logic                      vs,
  output logic                      de,
  output logic [CW-1:0]             r,
  output logic [CW-1:0]             g,
  output logic [CW-1:0]             b,
  output logic                      frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int RGB_W   = rgb_w(CW);
  localparam int CELL_SH = SCALE_LOG2 + GLYPH_PITCH_LOG2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] X_ORG  = HW'(X0);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] Y_ORG  = VW'(Y0);

  logic [HW-1:0]            hc;
  logic [VW-1:0]            vc;
  logic [5:0]               fcnt;
  logic [NCH*DIGITS*4-1:0]  vals_q;
  logic [NCH-1:0]           en_q;
  logic [NCH-1:0]           blink_q;
  logic [NCH*RGB_W-1:0]     fg_q;
  logic                     snap;

  logic                     de_p0, hs_p0, vs_p0, fs_p0;
  logic                     in_text_p0, row_on_p0, glyph_lit_p0, lit_p0;
  logic [HW-1:0]            xo_p0, dig_p0;
  logic [VW-1:0]            yo_p0, rowi_p0;
  logic [2:0]               gcol_p0, grow_p0;
  logic [3:0]               nib_p0;
  logic [RGB_W-1:0]         fgc_p0;

  assign snap = ce_pix && (hc == H_LAST) && (vc == V_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (ce_pix) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  // Frame registers: the overlay never looks at the live inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt    <= '0;
      vals_q  <= '0;
      en_q    <= '0;
      blink_q <= '0;
      fg_q    <= '0;
    end else if (snap) begin
      fcnt    <= fcnt + 6'd1;
      vals_q  <= values;
      en_q    <= ch_en;
      blink_q <= ch_blink;
      fg_q    <= fg;
    end
  end

  // Stage p0: decode of the current counter position.
  assign de_p0      = (hc < H_ACT) && (vc < V_ACT);
  assign hs_p0      = ((hc >= HS_BEG) && (hc < HS_END)) ? HS_POL : ~HS_POL;
  assign vs_p0      = ((vc >= VS_BEG) && (vc < VS_END)) ? VS_POL : ~VS_POL;
  assign fs_p0      = (hc == '0) && (vc == '0);
  assign xo_p0      = hc - X_ORG;
  assign yo_p0      = vc - Y_ORG;
  assign dig_p0     = xo_p0 >> CELL_SH;
  assign rowi_p0    = yo_p0 >> CELL_SH;
  assign gcol_p0    = 3'(xo_p0 >> SCALE_LOG2);
  assign grow_p0    = 3'(yo_p0 >> SCALE_LOG2);
  assign in_text_p0 = (hc >= X_ORG) && (vc >= Y_ORG) && (dig_p0 < HW'(DIGITS));

  // Most significant nibble of a row sits in the leftmost digit slot.
  always_comb begin
    nib_p0    = '0;
    fgc_p0    = '0;
    row_on_p0 = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      if (rowi_p0 == VW'(n)) begin
        row_on_p0 = en_q[n] & ~(blink_q[n] & fcnt[5]);
        fgc_p0    = fg_q[n*RGB_W +: RGB_W];
        for (int d = 0; d < DIGITS; d++) begin
          if (dig_p0 == HW'(d)) nib_p0 = vals_q[(n*DIGITS + DIGITS - 1 - d)*4 +: 4];
        end
      end
    end
  end

  hexglyph u_glyph (
    .digit (nib_p0),
    .col   (gcol_p0),
    .row   (grow_p0),
    .lit   (glyph_lit_p0)
  );

  assign lit_p0 = de_p0 & in_text_p0 & row_on_p0 & glyph_lit_p0;

  // Stage p1: registered outputs, one ce behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      {g, r, b}   <= '0;
    end else if (ce_pix) begin
      hs          <= hs_p0;
      vs          <= vs_p0;
      de          <= de_p0;
      frame_start <= fs_p0;
      if (lit_p0)     {g, r, b} <= fgc_p0;
      else if (de_p0) {g, r, b} <= bg;
      else            {g, r, b} <= '0;
    end
  end

endmodule
